// File: rtl/router_port_reader_if.sv
// Router output-port reader bus: FIFO read side, byte stream to the sink, per-packet status.
// Latency: none (wires only).
// Backpressure: out_ready from the sink; vld_out from the port FIFO.
interface router_port_reader_if;
    logic       vld_out;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       pkt_done;
    logic [5:0] pkt_len;
    logic       parity_err;
    logic       addr_err;
    logic       pkt_abort;

    // Reader side
    modport master (
        input  vld_out, data_in, out_ready,
        output read_enb, out_data, out_valid, out_last,
        output pkt_done, pkt_len, parity_err, addr_err, pkt_abort
    );

    // Port FIFO / sink / host side
    modport slave (
        output vld_out, data_in, out_ready,
        input  read_enb, out_data, out_valid, out_last,
        input  pkt_done, pkt_len, parity_err, addr_err, pkt_abort
    );
endinterface

// File: rtl/router_port_reader.sv
// Drains one router output port: header, payload, parity; forwards payload, checks addr/parity.
// Latency: read_enb -> out_valid 2 clocks; 1 byte/clk while the sink is ready.
// Backpressure: 2-entry skid buffer; reads issued only while occupancy + in-flight reads < 2.
module router_port_reader #(
    parameter logic [1:0] PORT_ID     = 2'b00,
    parameter int         WAIT_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 soft_reset,
    router_port_reader_if.master bus
);
    localparam logic [4:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 5'(WAIT_CYCLES - 1) : 5'd0;

    typedef enum logic [2:0] {IDLE, WAIT, HDR, PAYLOAD, PARITY, DONE} state_t;
    typedef enum logic [1:0] {K_HDR, K_PAY, K_PAR} kind_t;

    state_t     state, state_nxt;
    logic [4:0] wait_cnt;
    logic [5:0] rd_cnt;
    logic [5:0] len_r;
    logic       read_need, rd_go, abort, credit, push, pop, last_pay_rd, out_vld;
    kind_t      kind_now;
    logic       pend, pend_last;
    kind_t      pend_kind;
    logic [7:0] acc;
    logic       addr_bad, par_bad;
    logic [8:0] buf0, buf1;
    logic       wr_ptr, rd_ptr;
    logic [1:0] occ;
    logic [2:0] load;
    logic       pkt_done_r, pkt_abort_r, parity_err_r, addr_err_r;

    assign abort       = soft_reset && (state != IDLE);
    assign out_vld     = (occ != 2'd0);
    assign pop         = out_vld && bus.out_ready;
    assign push        = pend && (pend_kind == K_PAY);
    // Occupancy after this cycle's pop plus the read whose data arrives next cycle.
    assign load        = {1'b0, occ} - {2'b0, pop} + {2'b0, pend};
    assign credit      = (load < 3'd2);
    assign last_pay_rd = (rd_cnt == len_r - 6'd1);
    assign read_need   = ((state == HDR || state == PARITY) && rd_cnt == 6'd0) ||
                         (state == PAYLOAD && rd_cnt < len_r);
    assign rd_go       = bus.vld_out && read_need && credit;
    assign kind_now    = (state == HDR) ? K_HDR : ((state == PAYLOAD) ? K_PAY : K_PAR);

    assign bus.read_enb   = rd_go;
    assign bus.out_valid  = out_vld;
    assign bus.out_data   = rd_ptr ? buf1[7:0] : buf0[7:0];
    assign bus.out_last   = out_vld && (rd_ptr ? buf1[8] : buf0[8]);
    assign bus.pkt_done   = pkt_done_r;
    assign bus.pkt_abort  = pkt_abort_r;
    assign bus.pkt_len    = len_r;
    assign bus.parity_err = parity_err_r;
    assign bus.addr_err   = addr_err_r;

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; an abort from any busy state returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.vld_out) state_nxt = (WAIT_CYCLES == 0) ? HDR : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = HDR;
            HDR:     if (pend) state_nxt = (bus.data_in[7:2] != 6'd0) ? PAYLOAD : PARITY;
            PAYLOAD: if (rd_go && last_pay_rd) state_nxt = PARITY;
            PARITY:  if (pend && pend_kind == K_PAR) state_nxt = DONE;
            DONE:    if (occ == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Per-state counters: wait cycles and reads issued, cleared on every state change
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 5'd0;
            rd_cnt   <= 6'd0;
        end else if (state_nxt != state) begin
            wait_cnt <= 5'd0;
            rd_cnt   <= 6'd0;
        end else begin
            if (state == WAIT) wait_cnt <= wait_cnt + 5'd1;
            if (rd_go)         rd_cnt   <= rd_cnt + 6'd1;
        end
    end

    // Returned-byte handling, skid buffer, parity accumulation and status pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend         <= 1'b0;
            pend_last    <= 1'b0;
            pend_kind    <= K_HDR;
            len_r        <= 6'd0;
            acc          <= 8'd0;
            addr_bad     <= 1'b0;
            par_bad      <= 1'b0;
            buf0         <= 9'd0;
            buf1         <= 9'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
            pkt_done_r   <= 1'b0;
            pkt_abort_r  <= 1'b0;
            parity_err_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            pkt_done_r  <= 1'b0;
            pkt_abort_r <= 1'b0;
            if (abort) begin
                // Drop buffered and in-flight bytes; no completion for this packet
                pend         <= 1'b0;
                wr_ptr       <= 1'b0;
                rd_ptr       <= 1'b0;
                occ          <= 2'd0;
                acc          <= 8'd0;
                pkt_abort_r  <= 1'b1;
                parity_err_r <= 1'b0;
                addr_err_r   <= 1'b0;
            end else begin
                pend      <= rd_go;
                pend_kind <= kind_now;
                pend_last <= (state == PAYLOAD) && last_pay_rd;
                if (pend && pend_kind == K_HDR) begin
                    len_r    <= bus.data_in[7:2];
                    addr_bad <= (bus.data_in[1:0] != PORT_ID);
                    acc      <= bus.data_in;
                end
                if (push) begin
                    if (wr_ptr) buf1 <= {pend_last, bus.data_in};
                    else        buf0 <= {pend_last, bus.data_in};
                    wr_ptr <= ~wr_ptr;
                    acc    <= acc ^ bus.data_in;
                end
                if (pend && pend_kind == K_PAR) par_bad <= (bus.data_in != acc);
                if (pop) rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, push} - {1'b0, pop};
                if (state == DONE && occ == 2'd0) begin
                    pkt_done_r   <= 1'b1;
                    parity_err_r <= par_bad;
                    addr_err_r   <= addr_bad;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_port_reader.sv
// Bench for router_port_reader: port FIFO model, random sink/stall stimulus, packet-level scoreboard.
// Latency: n/a.
// Backpressure: sink ready and FIFO valid are driven from the bench each cycle.
module tb_router_port_reader;
    localparam logic [1:0] PORT_ID     = 2'b00;
    localparam int         WAIT_CYCLES = 4;

    logic clock = 1'b0;
    logic resetn;
    logic soft_reset;

    router_port_reader_if bus ();

    router_port_reader #(.PORT_ID(PORT_ID), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] fifo_q[$];     // {is_payload, byte} as stored in the router FIFO
    logic [8:0] exp_q[$];      // expected {last, byte} stream
    logic [8:0] obs_q[$];
    logic [7:0] exp_done_q[$]; // expected {parity_err, addr_err, pkt_len}
    logic [7:0] done_q[$];
    logic [7:0] pay[$];
    logic       rd_prev   = 1'b0;
    logic [7:0] rd_byte   = 8'd0;
    logic       ready_drv = 1'b1;
    logic       gate_drv  = 1'b1;
    logic       sr_drv    = 1'b0;
    logic       rd_seen   = 1'b0;
    int         held      = 0;
    int         held_max  = 0;
    int         rd_no_vld = 0;
    int         abort_cnt = 0;

    // One clock: drive at negedge, sample #1 later, model the registered FIFO read.
    task automatic step();
        logic [8:0] e;
        @(negedge clock);
        bus.data_in   = rd_prev ? rd_byte : 8'($urandom);
        bus.vld_out   = (fifo_q.size() > 0) && gate_drv;
        bus.out_ready = ready_drv;
        soft_reset    = sr_drv;
        #1;
        rd_seen = bus.read_enb;
        if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_last, bus.out_data});
            held--;
        end
        if (bus.pkt_done) done_q.push_back({bus.parity_err, bus.addr_err, bus.pkt_len});
        if (bus.pkt_abort) abort_cnt++;
        if (bus.read_enb && !bus.vld_out) rd_no_vld++;
        rd_prev = 1'b0;
        if (bus.read_enb && fifo_q.size() > 0) begin
            e       = fifo_q.pop_front();
            rd_byte = e[7:0];
            rd_prev = 1'b1;
            if (e[8]) held++;
        end
        if (held > held_max) held_max = held;
        if (soft_reset) begin
            fifo_q.delete();
            rd_prev = 1'b0;
            held    = 0;
        end
    endtask

    // Reference model: build the packet bytes and the expected output from the packet rules.
    task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input logic [7:0] flip);
        logic [7:0] hdr, x;
        hdr = {len, addr};
        x   = hdr;
        fifo_q.push_back({1'b0, hdr});
        for (int i = 0; i < int'(len); i++) begin
            fifo_q.push_back({1'b1, pay[i]});
            x = x ^ pay[i];
            exp_q.push_back({(i == int'(len) - 1), pay[i]});
        end
        fifo_q.push_back({1'b0, x ^ flip});
        exp_done_q.push_back({((x ^ flip) != x), (addr != PORT_ID), len});
    endtask

    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        exp_done_q.delete();
        held_max = 0;
    endtask

    task automatic run_done(input int target, input int budget);
        int c = 0;
        while (done_q.size() < target && c < budget) begin
            step();
            c++;
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.read_enb !== 1'b0)
            $display("FAIL reset_valid_rd: out_valid=%b read_enb=%b required 0 0", bus.out_valid, bus.read_enb);
        else n_pass++;
        n_checks++;
        if ({bus.pkt_done, bus.pkt_abort, bus.parity_err, bus.addr_err, bus.out_last} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000",
                     {bus.pkt_done, bus.pkt_abort, bus.parity_err, bus.addr_err, bus.out_last});
        else n_pass++;
        n_checks++;
        if (bus.pkt_len !== 6'd0) $display("FAIL reset_len: got %0d required 0", bus.pkt_len);
        else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.read_enb !== 1'b0 || bus.pkt_done !== 1'b0)
            $display("FAIL idle_after_reset: out_valid=%b read_enb=%b pkt_done=%b required 0 0 0",
                     bus.out_valid, bus.read_enb, bus.pkt_done);
        else n_pass++;
    endtask

    task automatic test_basic();
        int bad = 0;
        logic [7:0] got;
        clear_sb();
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(6'd3, 2'd0, 8'h00);
        run_done(1, 200);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_q.size() != 3)
            $display("FAIL basic_bytes: got %0d bytes (%0d wrong) required 3", obs_q.size(), bad);
        else n_pass++;
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (done_q.size() != 1 || got !== 8'h03)
            $display("FAIL basic_status: done=%0d status=%h required done=1 status=03", done_q.size(), got);
        else n_pass++;
    endtask

    task automatic test_parity_err();
        int bad = 0;
        logic [7:0] got;
        clear_sb();
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(6'd3, 2'd0, 8'h01);
        run_done(1, 200);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_q.size() != 3)
            $display("FAIL parity_bytes: got %0d bytes (%0d wrong) required 3", obs_q.size(), bad);
        else n_pass++;
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (done_q.size() != 1 || got !== 8'h83)
            $display("FAIL parity_status: done=%0d status=%h required done=1 status=83", done_q.size(), got);
        else n_pass++;
    endtask

    task automatic test_addr_err();
        logic [7:0] got;
        clear_sb();
        pay.delete();
        send_pkt(6'd0, 2'd1, 8'h00);
        run_done(1, 200);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL addr_no_bytes: got %0d bytes required 0", obs_q.size());
        else n_pass++;
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (done_q.size() != 1 || got !== 8'h40)
            $display("FAIL addr_status: done=%0d status=%h required done=1 status=40", done_q.size(), got);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int c = 0;
        logic [7:0] got;
        clear_sb();
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
        send_pkt(6'd8, PORT_ID, 8'h00);
        while (obs_q.size() < 2 && c < 100) begin step(); c++; end
        ready_drv = 1'b0;
        repeat (5) step();
        ready_drv = 1'b1;
        run_done(1, 300);
        n_checks++;
        if (held_max > 2) $display("FAIL bp_buffered: got %0d bytes held required <= 2", held_max);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_q.size() != 8)
            $display("FAIL bp_bytes: got %0d bytes (%0d wrong) required 8", obs_q.size(), bad);
        else n_pass++;
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (done_q.size() != 1 || got !== exp_done_q[0])
            $display("FAIL bp_status: done=%0d status=%h required done=1 status=%h",
                     done_q.size(), got, exp_done_q[0]);
        else n_pass++;
    endtask

    task automatic test_abort();
        int bad = 0;
        int c = 0;
        logic [7:0] got;
        clear_sb();
        abort_cnt = 0;
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
        send_pkt(6'd6, PORT_ID, 8'h00);
        while (obs_q.size() < 2 && c < 100) begin step(); c++; end
        sr_drv = 1'b1;
        step();
        sr_drv = 1'b0;
        step();
        n_checks++;
        if (bus.pkt_abort !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL abort_pulse: pkt_abort=%b out_valid=%b required 1 0", bus.pkt_abort, bus.out_valid);
        else n_pass++;
        repeat (20) step();
        n_checks++;
        if (done_q.size() != 0 || abort_cnt != 1)
            $display("FAIL abort_no_done: pkt_done=%0d aborts=%0d required 0 1", done_q.size(), abort_cnt);
        else n_pass++;
        clear_sb();
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
        send_pkt(6'd5, PORT_ID, 8'h00);
        run_done(1, 300);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (bad != 0 || obs_q.size() != 5 || done_q.size() != 1 || got !== exp_done_q[0])
            $display("FAIL abort_next_pkt: bytes=%0d wrong=%0d done=%0d status=%h required 5 0 1 %h",
                     obs_q.size(), bad, done_q.size(), got, exp_done_q[0]);
        else n_pass++;
    endtask

    task automatic test_wait_timing();
        int first = -1;
        logic [7:0] got;
        clear_sb();
        repeat (5) step();
        pay = '{8'h5A};
        send_pkt(6'd1, PORT_ID, 8'h00);
        for (int i = 0; i < 40 && first < 0; i++) begin
            step();
            if (rd_seen) first = i;
        end
        n_checks++;
        if (first != WAIT_CYCLES + 1)
            $display("FAIL wait_first_read: got %0d cycles required %0d", first, WAIT_CYCLES + 1);
        else n_pass++;
        run_done(1, 200);
        got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
        n_checks++;
        if (done_q.size() != 1 || got !== 8'h01)
            $display("FAIL wait_status: done=%0d status=%h required 1 01", done_q.size(), got);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        int dbad = 0;
        int c = 0;
        int npkt = 40;
        logic [5:0] len;
        clear_sb();
        rd_no_vld = 0;
        for (int p = 0; p < npkt; p++) begin
            len = 6'($urandom_range(0, 20));
            pay.delete();
            for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
            send_pkt(len, 2'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        end
        while (done_q.size() < npkt && c < 20000) begin
            ready_drv = ($urandom_range(0, 3) != 0);
            gate_drv  = ($urandom_range(0, 6) != 0);
            step();
            c++;
        end
        ready_drv = 1'b1;
        gate_drv  = 1'b1;
        repeat (4) step();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_q.size() != exp_q.size())
            $display("FAIL rand_bytes: got %0d bytes (%0d wrong) required %0d", obs_q.size(), bad, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_done_q.size(); i++)
            if (i >= done_q.size() || done_q[i] !== exp_done_q[i]) dbad++;
        n_checks++;
        if (dbad != 0 || done_q.size() != npkt)
            $display("FAIL rand_status: got %0d packets (%0d wrong) required %0d", done_q.size(), dbad, npkt);
        else n_pass++;
        n_checks++;
        if (rd_no_vld != 0 || held_max > 2)
            $display("FAIL rand_flow: reads without vld_out=%0d max held=%0d required 0 <=2", rd_no_vld, held_max);
        else n_pass++;
    endtask

    initial begin
        resetn        = 1'b0;
        soft_reset    = 1'b0;
        bus.vld_out   = 1'b0;
        bus.data_in   = 8'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_addr_err();
        test_backpressure();
        test_abort();
        test_wait_timing();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
